// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer
// Captures one frame of BINS 24-bit magnitudes into a ping-pong buffer and
// streams each completed bank to serial_TX as a framed packet:
//   SYNC0, SYNC1, seq, 3*BINS payload bytes (MSB first per bin), XOR checksum.
// The capture side and the transmit side run independently; the two
// per-bank full flags are the only coupling between them.
module tx_frame_sequencer #(
  parameter int         BINS  = 16,
  parameter logic [7:0] SYNC0 = 8'hA5,
  parameter logic [7:0] SYNC1 = 8'h5A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] result,
  input  logic        result_valid,
  input  logic        frame_start,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_new_data,
  output logic        frame_sent,
  output logic        frame_drop,
  output logic        sync_err,
  output logic [7:0]  drop_cnt
);

  localparam int             IW       = (BINS > 1) ? $clog2(BINS) : 1;
  localparam int             AW       = IW + 1;
  localparam int             DEPTH    = 2 * BINS;
  localparam logic [7:0]     LAST_K   = 8'(3 * BINS + 3);
  localparam logic [IW-1:0]  LAST_BIN = IW'(BINS - 1);

  // ---------------------------------------------------------------------
  // Shared storage and bank flags
  // ---------------------------------------------------------------------
  logic [23:0]   mem [DEPTH];
  logic [23:0]   rd_data_reg;
  logic [1:0]    full_reg;
  logic [1:0]    full_next;
  logic          wbank_reg;
  logic          rbank_reg;

  // ---------------------------------------------------------------------
  // Capture side
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    CAP_WAIT_SOF = 2'd0,
    CAP_FILL     = 2'd1,
    CAP_DISCARD  = 2'd2
  } cap_state_t;

  cap_state_t    cap_state_reg;
  cap_state_t    cap_state_next;
  logic [IW-1:0] idx_reg;
  logic [7:0]    drop_cnt_reg;
  logic          sof;
  logic          wbank_full;
  logic          wr_en;
  logic          cap_done;
  logic [IW-1:0] wr_idx;
  logic [AW-1:0] wr_addr;

  assign sof        = result_valid && frame_start;
  assign wbank_full = full_reg[wbank_reg];
  assign wr_addr    = wbank_reg ? (AW'(BINS) + AW'(wr_idx)) : AW'(wr_idx);
  assign drop_cnt   = drop_cnt_reg;

  // Capture state register
  always_ff @(posedge clk) begin
    if (rst) cap_state_reg <= CAP_WAIT_SOF;
    else     cap_state_reg <= cap_state_next;
  end

  // Capture next state: a frame_start always restarts capture, from any state
  always_comb begin
    cap_state_next = cap_state_reg;
    if (sof) begin
      cap_state_next = wbank_full ? CAP_DISCARD : CAP_FILL;
    end else if (result_valid && (cap_state_reg == CAP_FILL) && (idx_reg == LAST_BIN)) begin
      cap_state_next = CAP_WAIT_SOF;
    end
  end

  // Capture outputs: write strobe, completion, abandon and drop pulses
  always_comb begin
    wr_en      = 1'b0;
    wr_idx     = idx_reg;
    cap_done   = 1'b0;
    sync_err   = 1'b0;
    frame_drop = 1'b0;
    if (sof) begin
      sync_err   = (cap_state_reg == CAP_FILL);
      frame_drop = wbank_full;
      wr_en      = !wbank_full;
      wr_idx     = '0;
    end else if (result_valid && (cap_state_reg == CAP_FILL)) begin
      wr_en    = 1'b1;
      cap_done = (idx_reg == LAST_BIN);
    end
  end

  // Capture datapath: bin index, write bank and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg      <= '0;
      wbank_reg    <= 1'b0;
      drop_cnt_reg <= 8'd0;
    end else begin
      if (sof)        idx_reg <= IW'(1);
      else if (wr_en) idx_reg <= cap_done ? '0 : idx_reg + IW'(1);
      if (cap_done) wbank_reg <= ~wbank_reg;
      if ((sync_err || frame_drop) && (drop_cnt_reg != 8'hFF))
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Transmit side
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_ISSUE = 2'd1,
    TX_HOLD  = 2'd2
  } tx_state_t;

  tx_state_t     tx_state_reg;
  tx_state_t     tx_state_next;
  logic [7:0]    k_reg;
  logic [1:0]    sub_reg;
  logic [IW-1:0] bin_reg;
  logic [IW-1:0] bin_next;
  logic [7:0]    csum_reg;
  logic [7:0]    seq_reg;
  logic [7:0]    last_byte_reg;
  logic [7:0]    cur_byte;
  logic          issue;
  logic          tx_done;
  logic          payload_k;
  logic          bin_adv;
  logic [AW-1:0] rd_addr;

  assign payload_k = (k_reg >= 8'd3) && (k_reg < LAST_K);
  // Advance the read address during HOLD so the next bin is already
  // registered out of the RAM when ISSUE drives its first byte.
  assign bin_adv   = (tx_state_reg == TX_HOLD) && payload_k && (sub_reg == 2'd2) &&
                     (bin_reg != LAST_BIN);
  assign bin_next  = bin_adv ? bin_reg + IW'(1) : bin_reg;
  assign rd_addr   = rbank_reg ? (AW'(BINS) + AW'(bin_next)) : AW'(bin_next);

  // TX state register
  always_ff @(posedge clk) begin
    if (rst) tx_state_reg <= TX_IDLE;
    else     tx_state_reg <= tx_state_next;
  end

  // TX next state: HOLD always lasts one cycle to cover serial_TX busy latency
  always_comb begin
    tx_state_next = tx_state_reg;
    case (tx_state_reg)
      TX_IDLE:  if (full_reg[rbank_reg]) tx_state_next = TX_ISSUE;
      TX_ISSUE: if (!tx_busy)            tx_state_next = TX_HOLD;
      TX_HOLD:  tx_state_next = (k_reg == LAST_K) ? TX_IDLE : TX_ISSUE;
      default:  tx_state_next = TX_IDLE;
    endcase
  end

  // TX outputs: load strobe, frame completion and the byte on the bus
  always_comb begin
    issue       = (tx_state_reg == TX_ISSUE) && !tx_busy;
    tx_done     = (tx_state_reg == TX_HOLD) && (k_reg == LAST_K);
    tx_new_data = issue;
    frame_sent  = tx_done;
    tx_data     = issue ? cur_byte : last_byte_reg;
  end

  // Byte map selected by the packet byte counter
  always_comb begin
    cur_byte = 8'd0;
    if (k_reg == 8'd0)        cur_byte = SYNC0;
    else if (k_reg == 8'd1)   cur_byte = SYNC1;
    else if (k_reg == 8'd2)   cur_byte = seq_reg;
    else if (k_reg == LAST_K) cur_byte = csum_reg;
    else begin
      case (sub_reg)
        2'd0:    cur_byte = rd_data_reg[23:16];
        2'd1:    cur_byte = rd_data_reg[15:8];
        default: cur_byte = rd_data_reg[7:0];
      endcase
    end
  end

  // TX datapath: byte counter, bin/sub-byte pointers, checksum, sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg         <= 8'd0;
      sub_reg       <= 2'd0;
      bin_reg       <= '0;
      csum_reg      <= 8'd0;
      seq_reg       <= 8'd0;
      last_byte_reg <= 8'd0;
      rbank_reg     <= 1'b0;
    end else if ((tx_state_reg == TX_IDLE) && full_reg[rbank_reg]) begin
      k_reg    <= 8'd0;
      sub_reg  <= 2'd0;
      bin_reg  <= '0;
      csum_reg <= 8'd0;
    end else if (issue) begin
      last_byte_reg <= cur_byte;
      if ((k_reg >= 8'd2) && (k_reg < LAST_K)) csum_reg <= csum_reg ^ cur_byte;
    end else if (tx_state_reg == TX_HOLD) begin
      k_reg <= k_reg + 8'd1;
      if (payload_k) begin
        sub_reg <= (sub_reg == 2'd2) ? 2'd0 : sub_reg + 2'd1;
        bin_reg <= bin_next;
      end
      if (tx_done) begin
        rbank_reg <= ~rbank_reg;
        seq_reg   <= seq_reg + 8'd1;
      end
    end
  end

  // Bank RAM: capture write port, registered read port for the TX side
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= result;
    rd_data_reg <= mem[rd_addr];
  end

  // Full flags are set by capture and cleared by TX independently
  always_comb begin
    full_next = full_reg;
    if (cap_done) full_next[wbank_reg] = 1'b1;
    if (tx_done)  full_next[rbank_reg] = 1'b0;
  end

  // Full flag register
  always_ff @(posedge clk) begin
    if (rst) full_reg <= 2'b00;
    else     full_reg <= full_next;
  end

endmodule

// File: doc/tx_frame_sequencer.md
# tx_frame_sequencer

Double-buffered frame scheduler between the SFTransform result bus and the serial_TX byte transmitter. Captures one 24-bit magnitude per frequency bin into a ping-pong buffer, then drives the shared serial_TX port with a framed packet: sync header, sequence number, payload bytes and an XOR checksum. It replaces the free-running `checkSums[22:15]` hookup and owns the `new_data`/`busy` handshake.

## Interface
- BINS, 16, bins per frame (2..64); payload is 3*BINS bytes
- SYNC0, 8'hA5, first header byte
- SYNC1, 8'h5A, second header byte
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-high reset
- result  in  24  transform bin value
- result_valid  in  1  one-cycle strobe, `result` valid
- frame_start  in  1  qualifies `result_valid`: this bin is bin 0 of a new frame
- tx_busy  in  1  serial_TX busy
- tx_data  out  8  byte to serial_TX
- tx_new_data  out  1  one-cycle load strobe to serial_TX
- frame_sent  out  1  one-cycle pulse after checksum byte issued
- frame_drop  out  1  one-cycle pulse when an incoming frame is discarded
- sync_err  out  1  one-cycle pulse when a partial frame is abandoned
- drop_cnt  out  8  saturating count of dropped/abandoned frames

## Operation
- Storage: two banks of BINS x 24 bits; flags `full[1:0]`, write pointer `wbank`, read pointer `rbank`; all 0 after reset.
- Capture FSM: WAIT_SOF, FILL, DISCARD.
  - WAIT_SOF: ignores `result_valid` unless `frame_start`=1. On frame_start: if `full[wbank]`=0, write bin 0, index=1, go FILL; otherwise pulse `frame_drop`, increment `drop_cnt`, go DISCARD.
  - FILL: each `result_valid` writes `result` at index, index++. When the write of index BINS-1 occurs: set `full[wbank]`, toggle `wbank`, go WAIT_SOF.
  - `frame_start` while in FILL (index>0): abandon partial bank (flag stays clear), pulse `sync_err`, increment `drop_cnt`, and treat the strobe as a fresh WAIT_SOF frame_start in the same cycle.
  - DISCARD: ignore data; the next `frame_start` is handled as in WAIT_SOF.
- TX FSM: IDLE, ISSUE, HOLD. Byte counter k over 0..3*BINS+3.
  - IDLE: when `full[rbank]`=1, k=0, checksum=0, go ISSUE.
  - ISSUE: when `tx_busy`=0, drive byte k on `tx_data` with `tx_new_data`=1 for that cycle, go HOLD; otherwise wait.
  - HOLD: one cycle unconditionally (covers serial_TX's one-cycle busy rise latency); k++; go ISSUE, or if the checksum byte was just issued: clear `full[rbank]`, toggle `rbank`, seq++, pulse `frame_sent`, go IDLE.
- Byte map: k=0 SYNC0; k=1 SYNC1; k=2 seq (8-bit, wraps 255 to 0, first frame 0); k=3..3*BINS+2 payload, bin b at k=3+3b as result[23:16], [15:8], [7:0]; final byte = XOR of seq and all payload bytes.
- `drop_cnt` saturates at 255; it never wraps.
- `tx_data` holds the last issued byte between strobes; it is 0 after reset.

## Timing
- Reset values: `tx_data`=0, `tx_new_data`=0, `frame_sent`=0, `frame_drop`=0, `sync_err`=0, `drop_cnt`=0, seq=0; both FSMs in idle states.
- Reset mid-frame aborts both FSMs in the same cycle. No further `tx_new_data` is issued, and a byte already loaded into serial_TX is not recalled.
- Start latency: with `tx_busy` low and the TX FSM idle, the first `tx_new_data` is asserted exactly 2 cycles after the cycle carrying the final bin's `result_valid`.
- Minimum byte spacing is 2 cycles; real spacing is set by `tx_busy`.
- Bank completion and TX release of the other bank in the same cycle are both honoured, because the flags are independent.
- A frame completes while the other bank is still full: the completed bank waits. A third frame arriving while both banks are full is dropped.

## Test plan
- BINS=4, tx_busy tied 0. Send frame 0x010203, 0x040506, 0x070809, 0x0A0B0C -> 16 bytes A5 5A 00 01 02 … 0C 0C, then one `frame_sent` pulse, with first strobe 2 cycles after the last valid.
- serial_TX model with busy held high for 10 cycles after each load -> no `tx_new_data` while busy is high, no lost or repeated byte, same 16-byte sequence.
- Three back-to-back frames while TX is stalled -> frames 1 and 2 are sent (seq 00, 01), frame 3 is dropped, `frame_drop` pulses once, `drop_cnt`=1.
- `frame_start` at bin 2 of a frame -> `sync_err` pulse, the new frame is captured from that bin, and the packet contains only the new frame's data.
- Send 256 frames -> seq wraps FF to 00. Force 300 drops -> `drop_cnt` holds at FF.
- Assert `rst` during payload byte 5 -> all outputs at reset values on the next cycle, and the next frame starts with seq 00.
